// File: rtl/mips_core_pkg.sv
// Shared front-end types and default sizing for the fetch/decode instruction queue.
package mips_core_pkg;

  localparam int INSTRUCTION_QUEUE_DEPTH = 8;
  localparam int FETCH_ENQ_WIDTH         = 2;
  localparam int FETCH_DEQ_WIDTH         = 2;
  localparam int INST_W                  = 32;

  // Default-width view of one queue entry; the queue itself re-declares it at DATA_W.
  typedef struct packed {
    logic [INST_W-1:0] data;
    logic [INST_W-1:0] pc;
  } inst;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_queue_ctrl.sv
// Pointer/occupancy control for fetch_queue_wide: accepted-lane count, effective take,
// enq_ready and flush. Honours FETCH_QUEUE_BYPASS_EN (empty-queue same-cycle bypass).
module fetch_queue_ctrl
  import mips_core_pkg::*;
#(
  parameter int DEPTH     = INSTRUCTION_QUEUE_DEPTH,
  parameter int ENQ_WIDTH = FETCH_ENQ_WIDTH,
  parameter int DEQ_WIDTH = FETCH_DEQ_WIDTH,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int EW       = $clog2(ENQ_WIDTH + 1),
  localparam int TW       = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_i,
  input  logic [ENQ_WIDTH-1:0] enq_valid_i,
  input  logic [TW-1:0]        deq_take_i,
  output logic [PTR_W-1:0]     rd_ptr_o,
  output logic [PTR_W-1:0]     wr_ptr_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 enq_ready_o,
  output logic [EW-1:0]        accept_o,
  output logic [EW-1:0]        skip_o
);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             run_stop;
  logic [EW-1:0]    run_len;
  logic [EW-1:0]    accept;
  logic [EW-1:0]    skip;
  logic             bypass;
  logic             enq_ready;
  logic [CNT_W-1:0] take_req, avail, take_eff, popped, stored;

  // Only the unbroken run of valid lanes starting at lane 0 is eligible.
  always_comb begin
    run_len  = '0;
    run_stop = 1'b0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (!run_stop && enq_valid_i[i]) run_len = EW'(i + 1);
      else                             run_stop = 1'b1;
    end
  end

  assign enq_ready = (count_q <= CNT_W'(DEPTH - ENQ_WIDTH));
  assign accept    = (enq_ready && !flush_i) ? run_len : '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count_q == '0) && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    take_req = (deq_take_i > TW'(DEQ_WIDTH)) ? CNT_W'(DEQ_WIDTH) : CNT_W'(deq_take_i);
    avail    = bypass ? CNT_W'(accept) : count_q;
    take_eff = flush_i ? '0 : ((take_req < avail) ? take_req : avail);
    // Bypassed entries consumed this cycle never enter storage.
    skip     = bypass ? EW'(take_eff) : '0;
    popped   = bypass ? '0 : take_eff;
    stored   = CNT_W'(accept) - CNT_W'(skip);
    rd_ptr_d = rd_ptr_q + PTR_W'(popped);
    wr_ptr_d = wr_ptr_q + PTR_W'(stored);
    count_d  = count_q + stored - popped;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr_o    = rd_ptr_q;
  assign wr_ptr_o    = wr_ptr_q;
  assign count_o     = count_q;
  assign enq_ready_o = enq_ready;
  assign accept_o    = accept;
  assign skip_o      = skip;

endmodule

// File: rtl/fetch_queue_wide.sv
// Multi-lane fetch-to-decode instruction queue: entry storage and lane muxing.
// Optional empty-queue bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue_wide
  import mips_core_pkg::*;
#(
  parameter int DEPTH     = INSTRUCTION_QUEUE_DEPTH,
  parameter int ENQ_WIDTH = FETCH_ENQ_WIDTH,
  parameter int DEQ_WIDTH = FETCH_DEQ_WIDTH,
  parameter int DATA_W    = INST_W,
  localparam int PTR_W    = $clog2(DEPTH),
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int EW       = $clog2(ENQ_WIDTH + 1),
  localparam int TW       = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [ENQ_WIDTH-1:0]          enq_valid,
  input  logic [ENQ_WIDTH*DATA_W-1:0]   enq_data,
  input  logic [ENQ_WIDTH*DATA_W-1:0]   enq_pc,
  output logic                          enq_ready,
  output logic [DEQ_WIDTH-1:0]          deq_valid,
  output logic [DEQ_WIDTH*DATA_W-1:0]   deq_data,
  output logic [DEQ_WIDTH*DATA_W-1:0]   deq_pc,
  input  logic [TW-1:0]                 deq_take,
  output logic [CNT_W-1:0]              count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [EW-1:0]    accept, skip;

  fetch_queue_ctrl #(
    .DEPTH     (DEPTH),
    .ENQ_WIDTH (ENQ_WIDTH),
    .DEQ_WIDTH (DEQ_WIDTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    .enq_valid_i (enq_valid),
    .deq_take_i  (deq_take),
    .rd_ptr_o    (rd_ptr),
    .wr_ptr_o    (wr_ptr),
    .count_o     (count),
    .enq_ready_o (enq_ready),
    .accept_o    (accept),
    .skip_o      (skip)
  );

  // Stored lanes are packed down past any bypass-consumed ones; pointer math wraps mod DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if ((EW'(i) < accept) && (EW'(i) >= skip)) begin
          mem_q[wr_ptr + PTR_W'(i) - PTR_W'(skip)] <= '{
            data: enq_data[i*DATA_W +: DATA_W],
            pc:   enq_pc[i*DATA_W +: DATA_W]
          };
        end
      end
    end
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam int BYP_N = (ENQ_WIDTH < DEQ_WIDTH) ? ENQ_WIDTH : DEQ_WIDTH;
  logic bypass;
  assign bypass = (count == '0) && !flush;
`endif

  always_comb begin
    deq_valid = '0;
    deq_data  = '0;
    deq_pc    = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      deq_valid[i]                 = (count > CNT_W'(i));
      deq_data[i*DATA_W +: DATA_W] = mem_q[rd_ptr + PTR_W'(i)].data;
      deq_pc[i*DATA_W +: DATA_W]   = mem_q[rd_ptr + PTR_W'(i)].pc;
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      for (int i = 0; i < BYP_N; i++) begin
        deq_valid[i]                 = (accept > EW'(i));
        deq_data[i*DATA_W +: DATA_W] = enq_data[i*DATA_W +: DATA_W];
        deq_pc[i*DATA_W +: DATA_W]   = enq_pc[i*DATA_W +: DATA_W];
      end
    end
`endif
  end

endmodule

// File: doc/fetch_queue_wide.md
# fetch_queue_wide

Parametrised multi-lane instruction queue between the i-cache/fetch stage and decode. Each cycle it accepts up to ENQ_WIDTH fetched instructions, each with its PC, and presents up to DEQ_WIDTH oldest entries to decode. Decode consumes a variable number of them through a take-count, so one queue serves both scalar and superscalar front ends. Flush and occupancy reporting are built in; an optional same-cycle bypass removes the empty-queue bubble.

## Interface
- DEPTH, 8, entries; power of two, ≥ max(ENQ_WIDTH, DEQ_WIDTH)
- ENQ_WIDTH, 2, instructions written per cycle
- DEQ_WIDTH, 2, instructions presented per cycle
- DATA_W, 32, instruction width; PC is also DATA_W bits
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  discard all contents (branch mispredict / redirect)
- enq_valid  in  ENQ_WIDTH  per-lane write request; lane 0 is oldest
- enq_data  in  ENQ_WIDTH*DATA_W  instructions, lane i at [i*DATA_W +: DATA_W]
- enq_pc  in  ENQ_WIDTH*DATA_W  PCs, same packing as enq_data
- enq_ready  out  1  free slots ≥ ENQ_WIDTH
- deq_valid  out  DEQ_WIDTH  lane i holds the (i+1)-th oldest entry
- deq_data  out  DEQ_WIDTH*DATA_W  instructions, oldest in lane 0
- deq_pc  out  DEQ_WIDTH*DATA_W  PCs
- deq_take  in  $clog2(DEQ_WIDTH+1)  number of entries consumed this cycle
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: circular array of {data, pc}, with rd_ptr and wr_ptr of $clog2(DEPTH) bits, plus a count register. Pointers wrap modulo DEPTH.
- Enqueue, all-or-nothing per cycle:
  - Accepted lanes are the contiguous run of set enq_valid bits starting at lane 0. Lanes above the first clear bit are dropped.
  - Write occurs only when enq_ready=1. Lane i goes to wr_ptr+i, and wr_ptr advances by the number of accepted lanes.
- enq_ready is derived from the registered count only, not from same-cycle deq_take. It is 1 while DEPTH−count ≥ ENQ_WIDTH.
- Dequeue:
  - deq_valid[i] = (count > i). Lane i shows entry rd_ptr+i.
  - Effective take = min(deq_take, count, DEQ_WIDTH). rd_ptr advances by the effective take.
- Count update: count_next = count + accepted − effective take. Simultaneous enqueue and dequeue are legal in every state.
- Flush has priority over everything. Pointers and count return to 0 next cycle; same-cycle enqueue and dequeue are ignored. Stored data is not cleared.
- Outputs for invalid lanes are don't-care but must be X-free. Storage resets to 0.

## Timing
- Reset: count=0, rd_ptr=wr_ptr=0, deq_valid=0, enq_ready=1, deq_data and deq_pc = 0.
- Enqueue-to-visible latency is 1 cycle without bypass: data written at edge N appears on deq_* after edge N.
- Dequeue is combinational from registers; deq_take acts at the next edge.
- Full (count=DEPTH): deq_valid is all ones up to DEQ_WIDTH, and enq_ready=0. A dequeue in the same cycle does not enable enqueue until the next cycle.
- Wrap: entries straddling index DEPTH−1 → 0 are read and written correctly within one cycle.
- rst_n low mid-operation: contents are lost, and outputs return to reset values after that edge.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count=0 and flush=0, deq lanes show enq lanes combinationally (deq_valid[i] = accepted lane i).
  - Bypassed entries consumed by deq_take are not written. Only the remainder is stored.
- Not defined: no combinational path from enq_* to deq_*. The empty queue always costs one cycle.

## Structure
- mips_core_pkg: the `inst` struct {data, pc}, plus the default constants INSTRUCTION_QUEUE_DEPTH and FETCH_ENQ_WIDTH/FETCH_DEQ_WIDTH.
- One sub-module, fetch_queue_ctrl: owns the pointers, count, accepted/effective-take arithmetic, enq_ready and flush. The top level holds storage and lane muxing.

## Test plan
- Reset, then enq 2 lanes (PC 0x100, 0x104) → next cycle count=2, deq_valid=2'b11, deq_pc lane0=0x100.
- Fill to count=8 with deq_take=0 → enq_ready=0 at count≥7 (DEPTH 8, ENQ 2). Extra enq_valid=2'b11 is dropped and count stays 8.
- Steady enq 2 / take 2 across 20 cycles → count constant, PCs strictly sequential through wrap at index 7→0.
- count=1, deq_take=2 → effective take 1, count=0, no underflow.
- count=5, flush=1 with enq_valid=2'b11 and deq_take=2 → next cycle count=0, deq_valid=0.
- enq_valid=2'b10 → nothing accepted, count unchanged. With FETCH_QUEUE_BYPASS_EN, empty queue plus enq 2'b01 → deq_valid[0]=1 in the same cycle.
